// File: rtl/mux_pkg.sv
// Shared definitions for the pipelined N:1 lane multiplexer and its dataset benches.
// Latency: n/a (types, constants and a pure next-state helper only).
// Backpressure: n/a.
//
// Contents:
//   DEF_NUM_IN / DEF_DATA_W / DEF_CNT_W  default geometry of the mux
//   occ_t                                output buffer occupancy (EMPTY, ONE, FULL)
//   occ_next()                           occupancy transition for one clock edge
package mux_pkg;

  localparam int DEF_NUM_IN = 8;
  localparam int DEF_DATA_W = 1;
  localparam int DEF_CNT_W  = 17;

  // Number of beats held in the 2-entry output buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  // Occupancy after one edge given this cycle's push and pop.
  // In EMPTY no pop is possible, in FULL no push is possible, so those
  // inputs are simply ignored in those states.
  function automatic occ_t occ_next(input occ_t cur, input logic push, input logic pop);
    occ_t nxt;
    nxt = cur;
    case (cur)
      EMPTY: begin
        if (push) nxt = ONE;
      end
      ONE: begin
        if (push && !pop)      nxt = FULL;
        else if (pop && !push) nxt = EMPTY;
        else                   nxt = ONE;
      end
      FULL: begin
        if (pop) nxt = ONE;
      end
      default: nxt = EMPTY;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mux_sel_comb.sv
// Combinational NUM_IN:1 lane select with select range check.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs every cycle.
//
// Ports:
//   lanes  in   NUM_IN*DATA_W  lane i = lanes[i*DATA_W +: DATA_W]
//   sel    in   SEL_W          lane index
//   data   out  DATA_W         selected lane, 0 when sel is out of range
//   err    out  1              sel >= NUM_IN
module mux_sel_comb
  import mux_pkg::*;
#(
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int DATA_W = DEF_DATA_W,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN*DATA_W-1:0] lanes,
  input  logic [SEL_W-1:0]         sel,
  output logic [DATA_W-1:0]        data,
  output logic                     err
);

  // A code that matches no lane index is exactly an out-of-range code, so
  // the range check falls out of the same compare loop. Only the matching
  // lane is ever routed, so unused lanes never reach the output.
  always_comb begin
    data = '0;
    err  = 1'b1;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel == SEL_W'(i)) begin
        data = lanes[i*DATA_W +: DATA_W];
        err  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/pipe_mux_n.sv
// Registered N:1 lane mux with valid/ready on both sides, 2-entry output buffer and beat counter.
// Latency: beat accepted at edge k is on out_* from edge k; 1 beat/cycle with out_ready held high.
// Backpressure: in_ready drops only when both entries are full; derived from registered state only.
//
// Ports:
//   clock, reset                    rising-edge clock, synchronous active-high reset
//   in_valid/in_ready               upstream handshake; in_data (lane vector) and in_sel ride with it
//   out_valid/out_ready             downstream handshake; out_data/out_sel/out_err ride with it
//   cnt_clr                         synchronous clear of beat_cnt (wins over a same-cycle pop)
//   beat_cnt                        wrapping count of output handshakes
module pipe_mux_n
  import mux_pkg::*;
#(
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int DATA_W = DEF_DATA_W,
  parameter int SEL_W  = $clog2(NUM_IN),
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]         in_sel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     out_err,
  input  logic                     cnt_clr,
  output logic [CNT_W-1:0]         beat_cnt
);

  occ_t              state;
  occ_t              state_nxt;
  logic              push;
  logic              pop;
  logic              valid_q;

  // Lane chosen before storage: only DATA_W bits per entry are kept.
  logic [DATA_W-1:0] sel_data;
  logic              sel_err;

  // head is what the outputs present; tail is the second-oldest beat.
  logic [DATA_W-1:0] head_data;
  logic [SEL_W-1:0]  head_sel;
  logic              head_err;
  logic [DATA_W-1:0] tail_data;
  logic [SEL_W-1:0]  tail_sel;
  logic              tail_err;

  logic [CNT_W-1:0]  cnt_q;

  mux_sel_comb #(
    .NUM_IN (NUM_IN),
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W)
  ) u_sel (
    .lanes (in_data),
    .sel   (in_sel),
    .data  (sel_data),
    .err   (sel_err)
  );

  // No path from out_ready: a FULL buffer refuses even if a pop is happening
  // this cycle, which keeps the upstream ready timing purely registered.
  assign in_ready  = !reset && (state != FULL);
  assign push      = in_valid && in_ready;
  assign pop       = valid_q && out_ready;
  assign state_nxt = occ_next(state, push, pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= EMPTY;
      valid_q   <= 1'b0;
      head_data <= '0;
      head_sel  <= '0;
      head_err  <= 1'b0;
      tail_data <= '0;
      tail_sel  <= '0;
      tail_err  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state   <= state_nxt;
      valid_q <= (state_nxt != EMPTY);

      // New beat goes straight to head when head is free now or is being
      // drained at this edge (ONE with push & pop); otherwise the tail
      // advances into head on a pop from FULL.
      if (push && ((state == EMPTY) || ((state == ONE) && pop))) begin
        head_data <= sel_data;
        head_sel  <= in_sel;
        head_err  <= sel_err;
      end else if (pop && (state == FULL)) begin
        head_data <= tail_data;
        head_sel  <= tail_sel;
        head_err  <= tail_err;
      end

      if (push && (state == ONE) && !pop) begin
        tail_data <= sel_data;
        tail_sel  <= in_sel;
        tail_err  <= sel_err;
      end

      // Clear has priority, so a beat popped in the clear cycle is not counted.
      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (pop) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign out_valid = valid_q;
  assign out_data  = head_data;
  assign out_sel   = head_sel;
  assign out_err   = head_err;
  assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_pipe_mux_n.sv
// Self-checking bench for pipe_mux_n: default 8x1-bit instance plus an 8x4-bit instance
// with 4-bit select and 4-bit counter. Each instance is mirrored by a queue-level model
// (FIFO of expected beats, handshake counts) advanced once per clock.
module tb_pipe_mux_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- instance A: NUM_IN=8, DATA_W=1, SEL_W=3, CNT_W=17
  logic        a_reset     = 1'b1;
  logic        a_in_valid  = 1'b0;
  logic        a_in_ready;
  logic [7:0]  a_in_data   = '0;
  logic [2:0]  a_in_sel    = '0;
  logic        a_out_valid;
  logic        a_out_ready = 1'b0;
  logic [0:0]  a_out_data;
  logic [2:0]  a_out_sel;
  logic        a_out_err;
  logic        a_cnt_clr   = 1'b0;
  logic [16:0] a_beat_cnt;

  pipe_mux_n u_dut_a (
    .clock     (clk),
    .reset     (a_reset),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .in_sel    (a_in_sel),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .out_sel   (a_out_sel),
    .out_err   (a_out_err),
    .cnt_clr   (a_cnt_clr),
    .beat_cnt  (a_beat_cnt)
  );

  // ---------------- instance B: NUM_IN=8, DATA_W=4, SEL_W=4, CNT_W=4
  logic        b_reset     = 1'b1;
  logic        b_in_valid  = 1'b0;
  logic        b_in_ready;
  logic [31:0] b_in_data   = '0;
  logic [3:0]  b_in_sel    = '0;
  logic        b_out_valid;
  logic        b_out_ready = 1'b0;
  logic [3:0]  b_out_data;
  logic [3:0]  b_out_sel;
  logic        b_out_err;
  logic        b_cnt_clr   = 1'b0;
  logic [3:0]  b_beat_cnt;

  pipe_mux_n #(
    .NUM_IN (8),
    .DATA_W (4),
    .SEL_W  (4),
    .CNT_W  (4)
  ) u_dut_b (
    .clock     (clk),
    .reset     (b_reset),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .in_sel    (b_in_sel),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .out_sel   (b_out_sel),
    .out_err   (b_out_err),
    .cnt_clr   (b_cnt_clr),
    .beat_cnt  (b_beat_cnt)
  );

  // ---------------- reference models
  typedef struct packed {
    logic [0:0] d;
    logic [2:0] s;
  } a_ent_t;

  a_ent_t a_q[$];
  int     a_exp_cnt = 0;
  int     b_size    = 0;
  int     b_exp_cnt = 0;

  // Drive one cycle on A, step the model across the edge, return 1 #1 after it.
  task automatic a_cycle(input logic rst, input logic v, input logic [7:0] d,
                         input logic [2:0] s, input logic ordy, output logic accepted);
    logic   push;
    logic   pop;
    a_ent_t e;
    a_reset     = rst;
    a_in_valid  = v;
    a_in_data   = d;
    a_in_sel    = s;
    a_out_ready = ordy;
    push = !rst && v && (a_q.size() < 2);
    pop  = (a_q.size() > 0) && ordy;
    @(posedge clk);
    #1;
    if (rst) begin
      a_q.delete();
      a_exp_cnt = 0;
    end else begin
      if (pop) begin
        void'(a_q.pop_front());
        a_exp_cnt = (a_exp_cnt + 1) % (1 << 17);
      end
      if (push) begin
        e.d = d[s];
        e.s = s;
        a_q.push_back(e);
      end
    end
    accepted = push;
  endtask

  task automatic b_cycle(input logic rst, input logic v, input logic [31:0] d,
                         input logic [3:0] s, input logic ordy, input logic clr);
    logic push;
    logic pop;
    b_reset     = rst;
    b_in_valid  = v;
    b_in_data   = d;
    b_in_sel    = s;
    b_out_ready = ordy;
    b_cnt_clr   = clr;
    push = !rst && v && (b_size < 2);
    pop  = (b_size > 0) && ordy;
    @(posedge clk);
    #1;
    if (rst) begin
      b_size    = 0;
      b_exp_cnt = 0;
    end else begin
      if (clr)      b_exp_cnt = 0;
      else if (pop) b_exp_cnt = (b_exp_cnt + 1) % 16;
      b_size = b_size + (push ? 1 : 0) - (pop ? 1 : 0);
    end
  endtask

  // ---------------- tests
  task automatic test_reset();
    logic acc;
    a_cycle(1'b1, 1'b1, 8'hFF, 3'd7, 1'b1, acc);
    a_cycle(1'b1, 1'b1, 8'hFF, 3'd7, 1'b1, acc);
    b_cycle(1'b1, 1'b1, 32'hFFFF_FFFF, 4'd9, 1'b1, 1'b0);
    b_cycle(1'b1, 1'b1, 32'hFFFF_FFFF, 4'd9, 1'b1, 1'b0);
    n_checks++;
    if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", a_in_ready); end
    n_checks++;
    if ({a_out_valid, a_out_data, a_out_sel, a_out_err} !== 6'd0) begin
      n_fail++; $display("FAIL reset_outputs_a: got v=%b d=%h s=%h e=%b want all 0", a_out_valid, a_out_data, a_out_sel, a_out_err);
    end
    n_checks++;
    if (a_beat_cnt !== 17'd0) begin n_fail++; $display("FAIL reset_cnt_a: got %0d want 0", a_beat_cnt); end
    n_checks++;
    if ({b_in_ready, b_out_valid, b_out_data, b_out_sel, b_out_err, b_beat_cnt} !== 15'd0) begin
      n_fail++; $display("FAIL reset_outputs_b: got rdy=%b v=%b d=%h s=%h e=%b c=%0d want all 0",
                         b_in_ready, b_out_valid, b_out_data, b_out_sel, b_out_err, b_beat_cnt);
    end
  endtask

  task automatic test_select_pattern();
    int   exp_tbl[8] = '{0, 1, 1, 0, 0, 1, 0, 1};
    logic acc;
    for (int i = 0; i < 8; i++) begin
      a_cycle(1'b0, 1'b1, 8'b1010_0110, 3'(i), 1'b1, acc);
      n_checks++;
      if (a_out_valid !== 1'b1 || a_out_data !== 1'(exp_tbl[i]) || a_out_sel !== 3'(i)) begin
        n_fail++; $display("FAIL pattern_sel%0d: got v=%b d=%b s=%0d want v=1 d=%0d s=%0d",
                           i, a_out_valid, a_out_data, a_out_sel, exp_tbl[i], i);
      end
      n_checks++;
      if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL pattern_ready%0d: got %b want 1", i, a_in_ready); end
    end
    a_cycle(1'b0, 1'b0, 8'h00, 3'd0, 1'b1, acc);
    n_checks++;
    if (a_beat_cnt !== 17'd8 || a_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL pattern_cnt: got cnt=%0d v=%b want cnt=8 v=0", a_beat_cnt, a_out_valid);
    end
  endtask

  task automatic test_out_of_range();
    logic [3:0]  sels[5] = '{4'd9, 4'd7, 4'd8, 4'd0, 4'd15};
    logic [31:0] d;
    logic [3:0]  exp_d;
    logic        exp_e;
    b_cycle(1'b0, 1'b0, 32'd0, 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      d     = $urandom;
      exp_e = (int'(sels[i]) >= 8);
      exp_d = exp_e ? 4'd0 : 4'(d >> (4 * int'(sels[i])));
      b_cycle(1'b0, 1'b1, d, sels[i], 1'b1, 1'b0);
      n_checks++;
      if (b_out_valid !== 1'b1 || b_out_data !== exp_d || b_out_sel !== sels[i] || b_out_err !== exp_e) begin
        n_fail++; $display("FAIL range_sel%0d: got v=%b d=%h s=%0d e=%b want v=1 d=%h s=%0d e=%b",
                           sels[i], b_out_valid, b_out_data, b_out_sel, b_out_err, exp_d, sels[i], exp_e);
      end
    end
    b_cycle(1'b0, 1'b0, 32'd0, 4'd0, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    logic acc;
    a_cycle(1'b0, 1'b1, 8'h0A, 3'd1, 1'b0, acc);
    a_cycle(1'b0, 1'b1, 8'h0A, 3'd2, 1'b0, acc);
    n_checks++;
    if (a_in_ready !== 1'b0 || a_out_sel !== 3'd1 || a_out_data !== 1'b1) begin
      n_fail++; $display("FAIL bp_full: got rdy=%b s=%0d d=%b want rdy=0 s=1 d=1", a_in_ready, a_out_sel, a_out_data);
    end
    a_cycle(1'b0, 1'b1, 8'h0A, 3'd3, 1'b0, acc);
    n_checks++;
    if (a_in_ready !== 1'b0 || a_out_sel !== 3'd1 || a_out_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_hold: got rdy=%b s=%0d v=%b want rdy=0 s=1 v=1", a_in_ready, a_out_sel, a_out_valid);
    end
    a_cycle(1'b0, 1'b1, 8'h0A, 3'd3, 1'b1, acc);
    n_checks++;
    if (a_in_ready !== 1'b1 || a_out_sel !== 3'd2 || a_out_data !== 1'b0) begin
      n_fail++; $display("FAIL bp_drain1: got rdy=%b s=%0d d=%b want rdy=1 s=2 d=0", a_in_ready, a_out_sel, a_out_data);
    end
    a_cycle(1'b0, 1'b1, 8'h0A, 3'd3, 1'b1, acc);
    n_checks++;
    if (a_out_valid !== 1'b1 || a_out_sel !== 3'd3 || a_out_data !== 1'b1) begin
      n_fail++; $display("FAIL bp_drain2: got v=%b s=%0d d=%b want v=1 s=3 d=1", a_out_valid, a_out_sel, a_out_data);
    end
    a_cycle(1'b0, 1'b0, 8'h00, 3'd0, 1'b1, acc);
    n_checks++;
    if (a_out_valid !== 1'b0 || a_beat_cnt !== 17'd11) begin
      n_fail++; $display("FAIL bp_end: got v=%b cnt=%0d want v=0 cnt=11", a_out_valid, a_beat_cnt);
    end
  endtask

  task automatic test_sweep();
    int         idx = 0;
    int         cyc = 0;
    logic       acc;
    logic       v;
    logic       ordy;
    logic [7:0] d;
    logic [2:0] s;
    a_cycle(1'b1, 1'b0, 8'h00, 3'd0, 1'b0, acc);
    while ((idx < 2048 || a_q.size() > 0) && cyc < 20000) begin
      v    = (idx < 2048) && ($urandom_range(0, 9) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      d    = 8'(idx >> 3);
      s    = 3'(idx);
      a_cycle(1'b0, v, d, s, ordy, acc);
      if (acc) idx++;
      cyc++;
      n_checks++;
      if (a_out_valid !== (a_q.size() > 0) || a_in_ready !== (a_q.size() < 2)) begin
        n_fail++; $display("FAIL sweep_hs cyc%0d: got v=%b rdy=%b want v=%b rdy=%b",
                           cyc, a_out_valid, a_in_ready, (a_q.size() > 0), (a_q.size() < 2));
      end
      if (a_q.size() > 0) begin
        n_checks++;
        if (a_out_data !== a_q[0].d || a_out_sel !== a_q[0].s || a_out_err !== 1'b0) begin
          n_fail++; $display("FAIL sweep_beat cyc%0d: got d=%b s=%0d e=%b want d=%b s=%0d e=0",
                             cyc, a_out_data, a_out_sel, a_out_err, a_q[0].d, a_q[0].s);
        end
      end
      n_checks++;
      if (a_beat_cnt !== 17'(a_exp_cnt)) begin
        n_fail++; $display("FAIL sweep_cnt cyc%0d: got %0d want %0d", cyc, a_beat_cnt, a_exp_cnt);
      end
    end
    n_checks++;
    if (idx != 2048 || a_q.size() != 0) begin
      n_fail++; $display("FAIL sweep_timeout: got %0d beats accepted, %0d pending want 2048, 0", idx, a_q.size());
    end
    n_checks++;
    if (a_beat_cnt !== 17'd2048) begin n_fail++; $display("FAIL sweep_total: got %0d want 2048", a_beat_cnt); end
  endtask

  task automatic test_cnt_wrap();
    b_cycle(1'b1, 1'b0, 32'd0, 4'd0, 1'b0, 1'b0);
    for (int k = 0; k <= 16; k++) begin
      b_cycle(1'b0, 1'b1, $urandom, 4'(k % 8), 1'b1, 1'b0);
      n_checks++;
      if (b_beat_cnt !== 4'(b_exp_cnt)) begin
        n_fail++; $display("FAIL wrap_cnt k%0d: got %0d want %0d", k, b_beat_cnt, b_exp_cnt);
      end
      if (k == 15) begin
        n_checks++;
        if (b_beat_cnt !== 4'd15) begin n_fail++; $display("FAIL wrap_top: got %0d want 15", b_beat_cnt); end
      end
      if (k == 16) begin
        n_checks++;
        if (b_beat_cnt !== 4'd0) begin n_fail++; $display("FAIL wrap_zero: got %0d want 0", b_beat_cnt); end
      end
    end
    b_cycle(1'b0, 1'b0, 32'd0, 4'd0, 1'b1, 1'b0);
    n_checks++;
    if (b_beat_cnt !== 4'd1 || b_beat_cnt !== 4'(b_exp_cnt)) begin
      n_fail++; $display("FAIL wrap_one: got %0d want 1", b_beat_cnt);
    end
    b_cycle(1'b0, 1'b1, 32'h1234_5678, 4'd3, 1'b0, 1'b0);
    b_cycle(1'b0, 1'b0, 32'd0, 4'd0, 1'b1, 1'b1);
    n_checks++;
    if (b_beat_cnt !== 4'd0 || b_out_valid !== 1'b0 || b_size != 0) begin
      n_fail++; $display("FAIL clr_with_pop: got cnt=%0d v=%b want cnt=0 v=0", b_beat_cnt, b_out_valid);
    end
  endtask

  task automatic test_reset_full();
    logic acc;
    a_cycle(1'b0, 1'b1, 8'hFF, 3'd5, 1'b0, acc);
    a_cycle(1'b0, 1'b1, 8'hFF, 3'd2, 1'b0, acc);
    n_checks++;
    if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_beat_cnt !== 17'd2048) begin
      n_fail++; $display("FAIL rst_full_pre: got rdy=%b v=%b cnt=%0d want rdy=0 v=1 cnt=2048", a_in_ready, a_out_valid, a_beat_cnt);
    end
    a_cycle(1'b1, 1'b0, 8'h00, 3'd0, 1'b0, acc);
    n_checks++;
    if (a_out_valid !== 1'b0 || a_beat_cnt !== 17'd0 || a_out_data !== 1'b0 || a_out_sel !== 3'd0) begin
      n_fail++; $display("FAIL rst_full_clear: got v=%b cnt=%0d d=%b s=%0d want all 0", a_out_valid, a_beat_cnt, a_out_data, a_out_sel);
    end
    a_reset = 1'b0;
    #1;
    n_checks++;
    if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_full_ready: got %b want 1", a_in_ready); end
    for (int i = 0; i < 3; i++) begin
      a_cycle(1'b0, 1'b0, 8'h00, 3'd0, 1'b1, acc);
      n_checks++;
      if (a_out_valid !== 1'b0 || a_beat_cnt !== 17'(a_exp_cnt)) begin
        n_fail++; $display("FAIL rst_full_stale%0d: got v=%b cnt=%0d want v=0 cnt=%0d", i, a_out_valid, a_beat_cnt, a_exp_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_select_pattern();
    test_out_of_range();
    test_backpressure();
    test_sweep();
    test_cnt_wrap();
    test_reset_full();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
